tohost_mailbox: RTL and testbench

- Memory-mapped responder on the core's data-store path. Captures riscv-tests writes to the tohost word and decodes them into pass/fail/test-number.
- Runs a cycle watchdog and presents one result record over a valid/ready handshake to the simulation reporter or an on-chip status port.
- Lets the core signal completion itself instead of the bench probing PC and register x3.

---
 rtl/tohost_mailbox.sv | 118 +++++++++++
 tb/tb_tohost_mailbox.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tohost_mailbox.sv
// Captures riscv-tests tohost stores, decodes pass/fail/test number, runs a
// cycle watchdog and presents a single result record over valid/ready.
module tohost_mailbox #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  output logic             wr_ready,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             result_pass,
  output logic             result_timeout,
  output logic [30:0]      result_testnum,
  output logic [CNT_W-1:0] cycle_count,
  output logic             halted
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REPORT = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [30:0]      testnum_q, testnum_d;
  logic             valid_q, halted_q, wr_ready_q;

  logic hit_c;
  logic expire_c;

  // Only a full-word store with bit 0 set ends the test; even values are syscalls.
  assign hit_c    = wr_en && (wr_addr == TOHOST_ADDR) && (wr_strb == 4'hF) && wr_data[0];
  assign expire_c = (cnt_q == TIMEOUT_LAST);

  // Next-state, counter and record capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    testnum_d = testnum_q;
    unique case (state_q)
      RUN: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (hit_c) begin
          pass_d    = (wr_data == 32'd1);
          timeout_d = 1'b0;
          testnum_d = (wr_data == 32'd1) ? 31'd0 : wr_data[31:1];
          cnt_d     = cnt_q;
          state_d   = REPORT;
        end else if (expire_c) begin
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          testnum_d = 31'd0;
          cnt_d     = cnt_q;
          state_d   = REPORT;
        end
      end
      REPORT: begin
        if (result_ready) begin
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and registered outputs; wr_ready rises on the first edge out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      testnum_q  <= 31'd0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      testnum_q  <= testnum_d;
      valid_q    <= (state_d == REPORT);
      halted_q   <= (state_d == HALT);
      wr_ready_q <= 1'b1;
    end
  end

  assign wr_ready       = wr_ready_q;
  assign result_valid   = valid_q;
  assign result_pass    = pass_q;
  assign result_timeout = timeout_q;
  assign result_testnum = testnum_q;
  assign cycle_count    = cnt_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_tohost_mailbox.sv
// Scoreboard bench for tohost_mailbox: expected records are queued when the
// ending store (or watchdog run) is set up and compared on each handshake.
module tb_tohost_mailbox;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int unsigned TMO    = 100;

  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic [30:0] testnum;
    logic [31:0] cnt;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        wr_ready;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        result_pass;
  logic        result_timeout;
  logic [30:0] result_testnum;
  logic [31:0] cycle_count;
  logic        halted;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  tohost_mailbox #(
    .TOHOST_ADDR   (TOHOST),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_ready      (wr_ready),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_pass   (result_pass),
    .result_timeout(result_timeout),
    .result_testnum(result_testnum),
    .cycle_count   (cycle_count),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Handshake monitor: pop the next expected record and compare every field.
  always @(negedge clk) begin
    if (rst && result_valid && result_ready) begin
      check("record_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        rec_t e;
        e = exp_q.pop_front();
        check("pass",    64'(result_pass),    64'(e.pass));
        check("timeout", 64'(result_timeout), 64'(e.timeout));
        check("testnum", 64'(result_testnum), 64'(e.testnum));
        check("cycles",  64'(cycle_count),    64'(e.cnt));
      end
    end
  end

  // Assert reset at a falling edge; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_valid",    64'(result_valid), 64'd0);
    check("rst_halted",   64'(halted),       64'd0);
    check("rst_wr_ready", 64'(wr_ready),     64'd0);
    check("rst_cycles",   64'(cycle_count),  64'd0);
    check("rst_pass",     64'(result_pass),  64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    wr_strb = strb;
    @(negedge clk);
    wr_en   = 1'b0;
    cyc++;
  endtask

  task automatic push(input logic pass, input logic tmo, input logic [30:0] tn, input int cnt);
    rec_t r;
    r.pass    = pass;
    r.timeout = tmo;
    r.testnum = tn;
    r.cnt     = 32'(cnt);
    exp_q.push_back(r);
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    check("halted", 64'(halted), 64'd1);
    check("valid_after_halt", 64'(result_valid), 64'd0);
  endtask

  initial begin
    @(negedge clk);

    // Pass at cycle 60, consumer always ready: single-cycle valid pulse.
    do_reset();
    result_ready = 1'b1;
    idle(1);
    check("wr_ready_up", 64'(wr_ready), 64'd1);
    idle(59);
    check("no_valid_before", 64'(result_valid), 64'd0);
    push(1'b1, 1'b0, 31'd0, cyc);
    store(TOHOST, 32'h1, 4'hF);
    check("valid_latency", 64'(result_valid), 64'd1);
    idle(1);
    check("valid_pulse_end", 64'(result_valid), 64'd0);
    wait_halt(10);

    // Fail code 7 -> testnum 3; later stores in REPORT and HALT are discarded.
    do_reset();
    result_ready = 1'b0;
    idle(10);
    push(1'b0, 1'b0, 31'd3, cyc);
    store(TOHOST, 32'h7, 4'hF);
    store(TOHOST, 32'h1, 4'hF);
    idle(3);
    check("report_valid",   64'(result_valid),   64'd1);
    check("report_pass",    64'(result_pass),    64'd0);
    check("report_testnum", 64'(result_testnum), 64'd3);
    check("report_cycles",  64'(cycle_count),    64'd10);
    result_ready = 1'b1;
    wait_halt(10);
    store(TOHOST, 32'h1, 4'hF);
    idle(2);
    check("halt_pass",    64'(result_pass),    64'd0);
    check("halt_testnum", 64'(result_testnum), 64'd3);
    check("halt_valid",   64'(result_valid),   64'd0);

    // Even value, partial strobe and neighbouring word are ignored.
    do_reset();
    result_ready = 1'b1;
    idle(5);
    store(TOHOST, 32'h2, 4'hF);
    store(TOHOST, 32'h1, 4'h3);
    store(TOHOST + 32'd4, 32'h1, 4'hF);
    store(TOHOST, 32'h0, 4'hF);
    store(TOHOST, 32'h1, 4'hF) ;
    // The last store above is a genuine hit; account for it.
    push(1'b1, 1'b0, 31'd0, cyc - 1);
    wait_halt(10);

    // Watchdog: no stores, record appears after the edge ending cycle 99.
    do_reset();
    result_ready = 1'b0;
    idle(99);
    check("tmo_not_yet", 64'(result_valid), 64'd0);
    idle(1);
    check("tmo_valid",   64'(result_valid),   64'd1);
    check("tmo_flag",    64'(result_timeout), 64'd1);
    push(1'b0, 1'b1, 31'd0, 99);
    result_ready = 1'b1;
    wait_halt(10);

    // Hit in the expiry cycle wins over the watchdog.
    do_reset();
    result_ready = 1'b1;
    idle(99);
    push(1'b0, 1'b0, 31'd2, 99);
    store(TOHOST, 32'h5, 4'hF);
    wait_halt(10);

    // Stall consumer 20 cycles, then reset mid-REPORT.
    do_reset();
    result_ready = 1'b0;
    idle(30);
    store(TOHOST, 32'h1, 4'hF);
    for (int i = 0; i < 20; i++) begin
      check("stall_valid",  64'(result_valid), 64'd1);
      check("stall_cycles", 64'(cycle_count),  64'd30);
      @(negedge clk);
    end
    check("stall_pass", 64'(result_pass), 64'd1);
    do_reset();
    idle(7);
    check("restart_cycles", 64'(cycle_count), 64'd7);
    result_ready = 1'b1;
    push(1'b0, 1'b0, 31'd20, cyc);
    store(TOHOST, 32'd41, 4'hF);
    wait_halt(10);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
